// File: rtl/xres_pad_ctrl_pkg.sv
// Shared types for the XRES pad controller: FSM states, reset-cause codes and a
// saturating 8-bit increment used by the optional event counters.
package xres_pad_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRUP     = 3'd0,
    IDLE      = 3'd1,
    FILTER    = 3'd2,
    ASSERT    = 3'd3,
    WAIT_HIGH = 3'd4,
    HOLD      = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_PIN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  // Pad control word order: {enable, en_vddio_sig, filt_in, inp_sel, disable_pullup}
  localparam logic [4:0] PAD_OFF = 5'b00000;
  localparam logic [4:0] PAD_ON  = 5'b11100;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/xres_sync.sv
// Multi-flop synchronizer for the asynchronous pad reset output; resets to 1 so a
// power-on reset never looks like a pin reset.
module xres_sync
  import xres_pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/xres_pad_ctrl.sv
// Core-side XRES pad controller: pad enable sequencing, pin debounce, reset stretching
// and SW reset arbitration. Optional event counters under XRES_PAD_CTRL_EVENT_CNT_EN.
module xres_pad_ctrl
  import xres_pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int PWRUP_CYCLES    = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       xres_h_n_in,
  input  logic       sw_reset_req,
  output logic       sw_reset_ack,
  output logic       pad_enable_h,
  output logic       pad_en_vddio_sig_h,
  output logic       pad_filt_in_h,
  output logic       pad_inp_sel_h,
  output logic       pad_disable_pullup_h,
  output logic       core_resetb,
  output logic [1:0] reset_cause,
  output logic       busy
`ifdef XRES_PAD_CTRL_EVENT_CNT_EN
  ,
  output logic [7:0] pin_event_cnt,
  output logic [7:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] PWRUP_TC = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             pend_sw, pend_sw_d;
  logic [4:0]       pad_ctl, pad_ctl_d;
  logic             core_resetb_d;
  logic [1:0]       reset_cause_d;
  logic             ack_d;
  logic             pin_sync;
  logic             pin_low;
  logic             pin_evt;
  logic             glitch_evt;

  xres_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .resetb (resetb),
    .d      (xres_h_n_in),
    .q      (pin_sync)
  );

  assign pin_low = ~pin_sync;

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    pend_sw_d     = pend_sw;
    pad_ctl_d     = pad_ctl;
    core_resetb_d = core_resetb;
    reset_cause_d = reset_cause;
    ack_d         = 1'b0;
    pin_evt       = 1'b0;
    glitch_evt    = 1'b0;

    case (state)
      PWRUP: begin
        if (cnt == PWRUP_TC) begin
          pad_ctl_d = PAD_ON;
          state_d   = HOLD;
          cnt_d     = '0;
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end

      // A SW request beats a pin sample seen in the same cycle
      IDLE: begin
        if (sw_reset_req) begin
          state_d   = ASSERT;
          pend_sw_d = 1'b1;
        end else if (pin_low) begin
          state_d = FILTER;
          cnt_d   = CNT_W'(1);
        end
      end

      FILTER: begin
        if (sw_reset_req) begin
          state_d   = ASSERT;
          pend_sw_d = 1'b1;
        end else if (!pin_low) begin
          state_d    = IDLE;
          glitch_evt = 1'b1;
        end else if (cnt == DEB_TC) begin
          state_d   = ASSERT;
          pend_sw_d = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end

      ASSERT: begin
        core_resetb_d = 1'b0;
        if (pend_sw) begin
          reset_cause_d = CAUSE_SW;
          ack_d         = 1'b1;
          state_d       = HOLD;
          cnt_d         = '0;
        end else begin
          reset_cause_d = CAUSE_PIN;
          pin_evt       = 1'b1;
          state_d       = WAIT_HIGH;
        end
      end

      WAIT_HIGH: begin
        if (!pin_low) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end

      // Any pin activity while stretching re-arms the stretch from the pin release
      HOLD: begin
        if (pin_low) begin
          state_d       = WAIT_HIGH;
          cnt_d         = '0;
          reset_cause_d = CAUSE_PIN;
        end else if (cnt == HOLD_TC) begin
          state_d       = IDLE;
          core_resetb_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end

      default: begin
        state_d = PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state        <= PWRUP;
      cnt          <= '0;
      pend_sw      <= 1'b0;
      pad_ctl      <= PAD_OFF;
      core_resetb  <= 1'b0;
      reset_cause  <= CAUSE_POR;
      sw_reset_ack <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      pend_sw      <= pend_sw_d;
      pad_ctl      <= pad_ctl_d;
      core_resetb  <= core_resetb_d;
      reset_cause  <= reset_cause_d;
      sw_reset_ack <= ack_d;
      busy         <= (state_d != IDLE);
    end
  end

  assign pad_enable_h         = pad_ctl[4];
  assign pad_en_vddio_sig_h   = pad_ctl[3];
  assign pad_filt_in_h        = pad_ctl[2];
  assign pad_inp_sel_h        = pad_ctl[1];
  assign pad_disable_pullup_h = pad_ctl[0];

`ifdef XRES_PAD_CTRL_EVENT_CNT_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      pin_event_cnt <= '0;
      glitch_cnt    <= '0;
    end else begin
      if (pin_evt) begin
        pin_event_cnt <= sat_inc8(pin_event_cnt);
      end
      if (glitch_evt) begin
        glitch_cnt <= sat_inc8(glitch_cnt);
      end
    end
  end
`else
  logic unused_evt;
  assign unused_evt = pin_evt ^ glitch_evt;
`endif

endmodule

// File: tb/tb_xres_pad_ctrl.sv
// Self-checking bench for xres_pad_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against an event-level reference model.
module tb_xres_pad_ctrl;

  localparam int PWR_N  = 8;
  localparam int DEB_N  = 16;
  localparam int HOLD_N = 64;

  logic       clock = 1'b0;
  logic       resetb;
  logic       xres_h_n_in;
  logic       sw_reset_req;
  logic       sw_reset_ack;
  logic       pad_enable_h;
  logic       pad_en_vddio_sig_h;
  logic       pad_filt_in_h;
  logic       pad_inp_sel_h;
  logic       pad_disable_pullup_h;
  logic       core_resetb;
  logic [1:0] reset_cause;
  logic       busy;
`ifdef XRES_PAD_CTRL_EVENT_CNT_EN
  logic [7:0] pin_event_cnt;
  logic [7:0] glitch_cnt;
`endif

  logic [4:0] pads;
  assign pads = {pad_enable_h, pad_en_vddio_sig_h, pad_filt_in_h, pad_inp_sel_h,
                 pad_disable_pullup_h};

  xres_pad_ctrl dut (
    .clock                (clock),
    .resetb               (resetb),
    .xres_h_n_in          (xres_h_n_in),
    .sw_reset_req         (sw_reset_req),
    .sw_reset_ack         (sw_reset_ack),
    .pad_enable_h         (pad_enable_h),
    .pad_en_vddio_sig_h   (pad_en_vddio_sig_h),
    .pad_filt_in_h        (pad_filt_in_h),
    .pad_inp_sel_h        (pad_inp_sel_h),
    .pad_disable_pullup_h (pad_disable_pullup_h),
    .core_resetb          (core_resetb),
    .reset_cause          (reset_cause),
    .busy                 (busy)
`ifdef XRES_PAD_CTRL_EVENT_CNT_EN
    ,
    .pin_event_cnt        (pin_event_cnt),
    .glitch_cnt           (glitch_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    int         low_len;
    int         exp_fall;
    int         exp_rise;
    logic [1:0] exp_cause;
  } vec_t;

  vec_t vecs[5];

  // Reference model state: pin history, power-up progress, pending assertion,
  // consecutive-low run length and remaining stretch (-1 = waiting for pin high)
  int m_p1, m_p2, m_pwr, m_powered, m_core, m_cause, m_ack, m_pend;
  int m_lowrun, m_hold, m_pevt, m_glitch;

  task automatic model_reset();
    m_p1 = 1; m_p2 = 1; m_pwr = 0; m_powered = 0; m_core = 0; m_cause = 0;
    m_ack = 0; m_pend = 0; m_lowrun = 0; m_hold = 0; m_pevt = 0; m_glitch = 0;
  endtask

  task automatic model_step(input logic pin, input logic req);
    int s_low;
    s_low = (m_p2 == 0) ? 1 : 0;
    m_p2  = m_p1;
    m_p1  = (pin === 1'b1) ? 1 : 0;
    m_ack = 0;
    if (m_powered == 0) begin
      m_pwr++;
      if (m_pwr == PWR_N) begin
        m_powered = 1;
        m_hold    = HOLD_N;
      end
    end else if (m_pend != 0) begin
      m_core  = 0;
      m_cause = m_pend;
      if (m_pend == 2) begin
        m_ack  = 1;
        m_hold = HOLD_N;
      end else begin
        m_hold = -1;
        if (m_pevt < 255) m_pevt++;
      end
      m_pend = 0;
    end else if (m_core == 1) begin
      if (req === 1'b1) begin
        m_pend   = 2;
        m_lowrun = 0;
      end else if (s_low == 1) begin
        m_lowrun++;
        if (m_lowrun == DEB_N) begin
          m_pend   = 1;
          m_lowrun = 0;
        end
      end else if (m_lowrun > 0) begin
        m_lowrun = 0;
        if (m_glitch < 255) m_glitch++;
      end
    end else begin
      if (m_hold < 0) begin
        if (s_low == 0) m_hold = HOLD_N;
      end else if (s_low == 1) begin
        m_hold  = -1;
        m_cause = 1;
      end else begin
        m_hold--;
        if (m_hold == 0) m_core = 1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e, fall_e, rise_e, ack_e, acks, run_left;
    int exp_glitch, exp_pevt;

    vecs[0] = '{low_len: 10, exp_fall: 0,  exp_rise: 0,   exp_cause: 2'b00};
    vecs[1] = '{low_len: 15, exp_fall: 0,  exp_rise: 0,   exp_cause: 2'b00};
    vecs[2] = '{low_len: 16, exp_fall: 19, exp_rise: 84,  exp_cause: 2'b01};
    vecs[3] = '{low_len: 40, exp_fall: 19, exp_rise: 107, exp_cause: 2'b01};
    vecs[4] = '{low_len: 1,  exp_fall: 0,  exp_rise: 0,   exp_cause: 2'b00};

    // ---------------- power-on reset ----------------
    resetb = 1'b0; xres_h_n_in = 1'b1; sw_reset_req = 1'b0;
    #12;
    check("por_pads", 32'(pads), 32'd0);
    check("por_core_resetb", 32'(core_resetb), 32'd0);
    check("por_cause", 32'(reset_cause), 32'd0);
    check("por_ack", 32'(sw_reset_ack), 32'd0);
    check("por_busy", 32'(busy), 32'd1);
    @(negedge clock);
    resetb = 1'b1;
    n = 0;
    while (pad_enable_h !== 1'b1 && n < 50) begin step(); n++; end
    check("pwrup_pad_enable_edge", 32'(n), 32'd8);
    check("pwrup_pads_on", 32'(pads), 32'b11100);
    n = 0;
    while (core_resetb !== 1'b1 && n < 200) begin step(); n++; end
    check("pwrup_core_release", 32'(n), 32'd64);
    check("pwrup_cause", 32'(reset_cause), 32'd0);
    check("pwrup_busy_idle", 32'(busy), 32'd0);

    // ---------------- pin pulse table ----------------
    exp_glitch = 0; exp_pevt = 0;
    for (int v = 0; v < 5; v++) begin
      fall_e = 0; rise_e = 0;
      xres_h_n_in = 1'b0;
      for (int k = 1; k <= 130; k++) begin
        step();
        if (core_resetb === 1'b0 && fall_e == 0) fall_e = k;
        if (core_resetb === 1'b1 && fall_e != 0 && rise_e == 0) rise_e = k;
        if (k == vecs[v].low_len) xres_h_n_in = 1'b1;
      end
      check($sformatf("vec%0d_fall", v), 32'(fall_e), 32'(vecs[v].exp_fall));
      check($sformatf("vec%0d_rise", v), 32'(rise_e), 32'(vecs[v].exp_rise));
      if (vecs[v].exp_fall != 0) begin
        check($sformatf("vec%0d_cause", v), 32'(reset_cause), 32'(vecs[v].exp_cause));
        exp_pevt++;
      end else begin
        exp_glitch++;
      end
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
    end
`ifdef XRES_PAD_CTRL_EVENT_CNT_EN
    check("table_glitch_cnt", 32'(glitch_cnt), 32'(exp_glitch));
    check("table_pin_event_cnt", 32'(pin_event_cnt), 32'(exp_pevt));
`endif

    // ---------------- SW request from IDLE ----------------
    sw_reset_req = 1'b1;
    acks = 0; ack_e = 0; fall_e = 0; rise_e = 0;
    for (int k = 1; k <= 90; k++) begin
      step();
      if (sw_reset_ack === 1'b1) begin acks++; ack_e = k; sw_reset_req = 1'b0; end
      if (core_resetb === 1'b0 && fall_e == 0) fall_e = k;
      if (core_resetb === 1'b1 && fall_e != 0 && rise_e == 0) rise_e = k;
    end
    check("sw_ack_edge", 32'(ack_e), 32'd2);
    check("sw_ack_count", 32'(acks), 32'd1);
    check("sw_fall_edge", 32'(fall_e), 32'd2);
    check("sw_accept_to_release", 32'(rise_e - 1), 32'd65);
    check("sw_cause", 32'(reset_cause), 32'd2);

    // ---------------- SW and pin in the same IDLE cycle ----------------
    xres_h_n_in = 1'b0;
    acks = 0; ack_e = 0; fall_e = 0; rise_e = 0;
    for (int k = 1; k <= 90; k++) begin
      step();
      if (sw_reset_ack === 1'b1) begin acks++; ack_e = k; sw_reset_req = 1'b0; end
      if (core_resetb === 1'b0 && fall_e == 0) fall_e = k;
      if (core_resetb === 1'b1 && fall_e != 0 && rise_e == 0) rise_e = k;
      if (k == 2) begin sw_reset_req = 1'b1; xres_h_n_in = 1'b1; end
    end
    check("tie_ack_edge", 32'(ack_e), 32'd4);
    check("tie_ack_count", 32'(acks), 32'd1);
    check("tie_fall_edge", 32'(fall_e), 32'd4);
    check("tie_rise_edge", 32'(rise_e), 32'd68);
    check("tie_cause", 32'(reset_cause), 32'd2);

    // ---------------- pin pulse during HOLD restarts the stretch ----------------
    sw_reset_req = 1'b1;
    acks = 0; fall_e = 0; rise_e = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (sw_reset_ack === 1'b1) begin acks++; sw_reset_req = 1'b0; end
      if (core_resetb === 1'b0 && fall_e == 0) fall_e = k;
      if (core_resetb === 1'b1 && fall_e != 0 && rise_e == 0) rise_e = k;
      if (k == 20) xres_h_n_in = 1'b0;
      if (k == 23) xres_h_n_in = 1'b1;
    end
    check("holdpin_ack_count", 32'(acks), 32'd1);
    check("holdpin_rise_edge", 32'(rise_e), 32'd90);
    check("holdpin_cause", 32'(reset_cause), 32'd1);

    // ---------------- asynchronous reset during HOLD ----------------
    sw_reset_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (sw_reset_ack === 1'b1) sw_reset_req = 1'b0;
    end
    #2;
    resetb = 1'b0;
    #1;
    check("async_pads", 32'(pads), 32'd0);
    check("async_core_resetb", 32'(core_resetb), 32'd0);
    check("async_cause", 32'(reset_cause), 32'd0);
    check("async_ack", 32'(sw_reset_ack), 32'd0);
    check("async_busy", 32'(busy), 32'd1);
`ifdef XRES_PAD_CTRL_EVENT_CNT_EN
    check("async_glitch_cnt", 32'(glitch_cnt), 32'd0);
`endif

    // ---------------- randomized run against the reference model ----------------
    sw_reset_req = 1'b0; xres_h_n_in = 1'b1; run_left = 20;
    model_reset();
    @(negedge clock);
    resetb = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clock);
      model_step(xres_h_n_in, sw_reset_req);
      #1;
      check("rnd_core_resetb", 32'(core_resetb), 32'(m_core));
      check("rnd_cause", 32'(reset_cause), 32'(m_cause));
      check("rnd_ack", 32'(sw_reset_ack), 32'(m_ack));
      check("rnd_busy", 32'(busy),
            32'((m_core == 1 && m_pend == 0 && m_lowrun == 0) ? 0 : 1));
      check("rnd_pads", 32'(pads), 32'((m_powered == 1) ? 5'b11100 : 5'b00000));
`ifdef XRES_PAD_CTRL_EVENT_CNT_EN
      check("rnd_pin_event_cnt", 32'(pin_event_cnt), 32'(m_pevt));
      check("rnd_glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
`endif
      if (m_ack == 1) sw_reset_req = 1'b0;
      else if (sw_reset_req == 1'b0 && $urandom_range(0, 59) == 0) sw_reset_req = 1'b1;
      if (run_left == 0) begin
        if (xres_h_n_in == 1'b1) begin
          xres_h_n_in = 1'b0;
          run_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(14, 30))
                                                 : int'($urandom_range(1, 6));
        end else begin
          xres_h_n_in = 1'b1;
          run_left = int'($urandom_range(10, 120));
        end
      end else begin
        run_left--;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
